// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one trial subtraction per clock.
// Rev 1.0
`default_nettype none

module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         div_by_zero_o
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   wq_q, wq_d;
  logic [N-1:0]   dvsr_q, dvsr_d;
  logic [N:0]     prem_q, prem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     shifted_rem;
  logic [N:0]     trial;
  logic [N-1:0]   iter_wq;
  logic [N:0]     iter_prem;

  // The partial remainder stays below the divisor, so its MSB is always 0 before the shift.
  assign shifted_rem = {prem_q[N-1:0], wq_q[N-1]};
  assign trial       = shifted_rem - {1'b0, dvsr_q};
  assign iter_wq     = {wq_q[N-2:0], ~trial[N]};
  assign iter_prem   = trial[N] ? shifted_rem : trial;

  always_comb begin
    state_d = state_q;
    wq_d    = wq_q;
    dvsr_d  = dvsr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          if (divisor_i == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            wq_d    = dividend_i;
            dvsr_d  = divisor_i;
            prem_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      S_CALC: begin
        wq_d   = iter_wq;
        prem_d = iter_prem;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          quot_d  = iter_wq;
          rem_d   = iter_prem[N-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      wq_q    <= '0;
      dvsr_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wq_q    <= wq_d;
      dvsr_q  <= dvsr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;
  assign busy_o        = (state_q == S_CALC);
  assign done_o        = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an arithmetic model.
// Rev 1.0
`default_nettype none

module tb_seq_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         dbz;

  int vectors;
  int errors;

  logic [N-1:0] prev_q, prev_r;
  logic         prev_dbz;

  seq_divider #(.N(N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .busy_o       (busy),
    .done_o       (done),
    .div_by_zero_o(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands, let the next rising edge accept them, then scramble the inputs.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  // Called 1 time unit after the accepting edge; returns in the Done cycle.
  task automatic finish_op(input logic [N-1:0] a, input logic [N-1:0] b, input int inject_at);
    int lat;
    int exp_lat;
    int exp_q, exp_r;
    logic exp_dbz;
    if (b == 0) begin
      exp_q = (1 << N) - 1; exp_r = a; exp_dbz = 1'b1; exp_lat = 1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_dbz = 1'b0; exp_lat = N + 1;
    end
    lat = 1;
    while (done !== 1'b1 && lat <= 40) begin
      check("busy_in_calc", busy, 1);
      check("hold_q", quotient, prev_q);
      check("hold_r", remainder, prev_r);
      if (lat == inject_at) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", lat, exp_lat);
    check("busy_at_done", busy, 0);
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("div_by_zero", dbz, exp_dbz);
    prev_q   = N'(exp_q);
    prev_r   = N'(exp_r);
    prev_dbz = exp_dbz;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_pulse_width", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    logic [N-1:0] a, b;
    int lat;
    vectors = 0; errors = 0;
    prev_q = '0; prev_r = '0; prev_dbz = 1'b0;
    start = 1'b0; dividend = '0; divisor = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", dbz, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 20 / 3
    start_op(8'd20, 8'd3); finish_op(8'd20, 8'd3, 0); idle_cycle();

    // 100 / 7 then back-to-back 255 / 1
    start_op(8'd100, 8'd7); finish_op(8'd100, 8'd7, 0);
    start_op(8'd255, 8'd1);
    check("b2b_done_low", done, 0);
    finish_op(8'd255, 8'd1, 0); idle_cycle();

    // dividend below divisor, then equal operands
    start_op(8'd5, 8'd9); finish_op(8'd5, 8'd9, 0); idle_cycle();
    start_op(8'd255, 8'd255); finish_op(8'd255, 8'd255, 0); idle_cycle();

    // divide by zero, then a normal op clears the flag
    start_op(8'd14, 8'd0); finish_op(8'd14, 8'd0, 0); idle_cycle();
    start_op(8'd14, 8'd2); finish_op(8'd14, 8'd2, 0); idle_cycle();

    // Start during CALC is ignored
    start_op(8'd200, 8'd3); finish_op(8'd200, 8'd3, 3); idle_cycle();

    // asynchronous reset mid-calculation
    start_op(8'd200, 8'd3);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dbz", dbz, 0);
    lat = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat++;
    end
    check("arst_no_done", lat, 0);
    rst_n = 1'b1;
    prev_q = '0; prev_r = '0; prev_dbz = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", done, 0);
    start_op(8'd50, 8'd5); finish_op(8'd50, 8'd5, 0); idle_cycle();

    // randomized operations, mixing back-to-back and idle gaps
    for (int i = 0; i < 60; i++) begin
      a = N'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = N'($urandom_range(1, 3));
        default: b = N'($urandom);
      endcase
      start_op(a, b);
      finish_op(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N)) : 0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned integer divider for the enhanced processor ALU.
- Complements the single-cycle add/subtract unit: it computes quotient and remainder by restoring division, using one trial subtraction per clock.
- Sits beside the adder/subtractor and is controlled by the processor control FSM through a Start/Done handshake.

Parameters:
- n, 8, operand and result width in bits (minimum 2).

Ports:
- Clock  input  1  system clock, rising-edge active.
- Resetn  input  1  asynchronous active-low reset.
- Start  input  1  request a division; sampled on the rising edge.
- Dividend  input  n  unsigned dividend; sampled only when Start is accepted.
- Divisor  input  n  unsigned divisor; sampled only when Start is accepted.
- Quotient  output  n  registered quotient.
- Remainder  output  n  registered remainder.
- Busy  output  1  high while an iteration is in progress.
- Done  output  1  one-cycle pulse marking the cycle in which results become valid.
- DivByZero  output  1  registered flag, set with Done when the divisor was zero.

Behaviour:
- Reset (Resetn low, asynchronous): state IDLE; Quotient, Remainder, Busy, Done, DivByZero and all internal registers go to 0. A division in progress is aborted with no Done pulse. Release is synchronous to the next Clock edge.
- States:
  - IDLE: wait for Start.
  - CALC: perform iterations.
  - DONE: results valid, Done high.
- IDLE with Start=1, Divisor!=0:
  - Latch Dividend into the working quotient shift register and Divisor into the divisor register.
  - Clear the partial remainder (n+1 bits) and the iteration counter.
  - Go to CALC.
- IDLE with Start=1, Divisor==0: go straight to DONE with Quotient = all ones, Remainder = Dividend, DivByZero=1.
- CALC, one iteration per clock:
  - Shift {partial remainder, working quotient} left by 1.
  - Trial = partial remainder − {1'b0, divisor}, computed n+1 bits wide.
  - If trial MSB is 0: partial remainder ← trial and quotient LSB ← 1. Otherwise keep the shifted remainder and set quotient LSB ← 0.
  - After the n-th iteration, copy results to Quotient/Remainder, set DivByZero=0, and go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. Start is accepted in DONE exactly as in IDLE, which allows back-to-back operations.
- Busy=1 only in CALC.
- Start is ignored while in CALC; operands may change freely during CALC.
- Latency, measured from the Start-accepting edge E:
  - Normal division: Done is high in the cycle after edge E+n.
  - Divide-by-zero: Done is high in the cycle after edge E.
- Quotient, Remainder and DivByZero hold their values until the next operation completes. They do not change during CALC.
- Arithmetic rules:
  - Purely unsigned; no overflow is possible for a nonzero divisor.
  - Remainder < Divisor always holds.
  - Dividend < Divisor gives Quotient=0 and Remainder=Dividend.

Test Plan:
- n=8, Start with 20/3 -> Busy high for 8 cycles, then Done pulse with Quotient=6, Remainder=2, DivByZero=0.
- n=8, 100/7 then back-to-back 255/1 (Start asserted in the DONE cycle) -> first result Q=14, R=2; second result Q=255, R=0; each Done is a single-cycle pulse.
- n=8, 5/9 -> Q=0, R=5; then 255/255 -> Q=1, R=0.
- n=8, 14/0 -> Done in the cycle after the Start edge with Q=255, R=14, DivByZero=1, Busy never high. A following 14/2 gives Q=7, R=0 and clears DivByZero.
- n=8, start 200/3; pulse Start with 9/3 on the third CALC cycle and change the operands -> second Start ignored; result Q=66, R=2 with Done after 8 cycles.
- n=8, start 200/3; assert Resetn=0 mid-CALC -> all outputs 0 immediately, no Done pulse. After release, 50/5 -> Q=10, R=0.
